score_bcd_converter: RTL

- Sequential binary-to-BCD converter that sits directly upstream of the seven-segment hex drivers.
- Takes the binary score or combo count from game logic (GST_STATE_PLAY / GST_STATE_REPORT) and produces packed BCD nibbles, one per hex driver.
- Uses shift-add-3 (double dabble), one bit per clock, so no wide dividers are needed.
- Output is registered and stable between conversions, so displays never show intermediate values.

---
 rtl/score_bcd_converter_pkg.sv | 22 ++
 rtl/score_bcd_converter_add3.sv | 16 +
 rtl/score_bcd_converter.sv | 95 +++++++++
 3 files changed

// File: rtl/score_bcd_converter_pkg.sv
// Shared types and constants for the binary-to-BCD score converter.
package score_bcd_converter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned BCD_DIGIT_W = 4;

  // 10^n as a 64-bit constant, used for the elaboration-time overflow limit.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_bcd_converter_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
  import score_bcd_converter_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= BCD_DIGIT_W'(5)) begin
      dout = din + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock,
// with a registered, saturating result for the seven-segment drivers.
module score_bcd_converter
  import score_bcd_converter_pkg::*;
#(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow
);

  localparam int unsigned       SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned       CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0]       LIMIT = pow10(DIGITS);
  localparam logic [SCR_W-1:0]  SAT   = {DIGITS{4'h9}};

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   shreg;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_flag;
  logic               accept;
  logic               last_step;

  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    last_step = (state == SHIFT) && (cnt == CNT_W'(1));
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  // done is registered so it rises in the same cycle bcd_out/overflow change.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (accept) begin
        shreg    <= bin_in;
        scratch  <= '0;
        cnt      <= CNT_W'(BIN_W);
        ovf_flag <= (64'(bin_in) >= LIMIT);
      end else if (state == SHIFT) begin
        {scratch, shreg} <= {scratch_adj, shreg} << 1;
        cnt              <= cnt - CNT_W'(1);
      end
      if (state == DONE) begin
        bcd_out  <= ovf_flag ? SAT : scratch;
        overflow <= ovf_flag;
      end
    end
  end

endmodule
